// File: rtl/tdm_demux16.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux16
//  Purpose  : Serial TDM frame receiver. A sync strobe marks slot 0; each
//             en-qualified cycle captures one din bit into a shadow register.
//             A complete frame is published on dout (slot k -> dout[k]) with
//             a one-cycle dout_valid pulse; a sync that arrives mid-frame
//             discards the partial frame and pulses frame_err.
//  Option   : PARITY_CHECK_EN -- when defined, frames are 17 slots and
//             slot 16 carries an even-parity bit over the 16 data bits; a
//             parity mismatch pulses frame_err and leaves dout untouched.
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_demux16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sync,
  input  logic        din,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        frame_err,
  output logic [4:0]  slot
);

`ifdef PARITY_CHECK_EN
  localparam int unsigned c_nslots = 17;
`else
  localparam int unsigned c_nslots = 16;
`endif
  localparam logic [4:0] c_last_slot = 5'(c_nslots - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t                state_q;
  logic [4:0]            slot_q;
  logic [c_nslots-1:0]   shadow_q;
  logic [c_nslots-1:0]   shadow_d;
  logic [15:0]           dout_q;
  logic                  dout_valid_q;
  logic                  frame_err_q;
  logic                  w_last_slot;
  logic                  w_parity_ok;

  // Shadow image with the current din merged into the slot being captured;
  // used both for ordinary capture and for the final-slot publish/check.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < c_nslots; i++) begin
      if (slot_q == 5'(i)) begin
        shadow_d[i] = din;
      end
    end
  end

  assign w_last_slot = (slot_q == c_last_slot);

`ifdef PARITY_CHECK_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign w_parity_ok = ~(^shadow_d);
`else
  assign w_parity_ok = 1'b1;
`endif

  // Frame FSM: slot tracking, shadow capture and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      slot_q       <= 5'd0;
      shadow_q     <= '0;
      dout_q       <= 16'h0000;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses by default.
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (en) begin
        case (state_q)
          S_IDLE: begin
            // Bits arriving before a sync are not part of any frame.
            if (sync) begin
              shadow_q <= {{(c_nslots-1){1'b0}}, din};
              slot_q   <= 5'd1;
              state_q  <= S_RECV;
            end
          end
          S_RECV: begin
            if (sync) begin
              // Early sync: drop the partial frame and restart at slot 0.
              frame_err_q <= 1'b1;
              shadow_q    <= {{(c_nslots-1){1'b0}}, din};
              slot_q      <= 5'd1;
            end else if (w_last_slot) begin
              state_q  <= S_IDLE;
              slot_q   <= 5'd0;
              shadow_q <= '0;
              if (w_parity_ok) begin
                dout_q       <= shadow_d[15:0];
                dout_valid_q <= 1'b1;
              end else begin
                frame_err_q  <= 1'b1;
              end
            end else begin
              shadow_q <= shadow_d;
              slot_q   <= slot_q + 5'd1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            slot_q  <= 5'd0;
          end
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign slot       = slot_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux16
//  Purpose  : Self-checking bench for tdm_demux16. Frames are described at
//             the word level (value, length, gaps, abort, parity) and the
//             expected dout/pulse history is derived from those words.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux16;

`ifdef PARITY_CHECK_EN
  localparam int N = 17;
`else
  localparam int N = 16;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        sync;
  logic        din;
  logic [15:0] dout;
  logic        dout_valid;
  logic        frame_err;
  logic [4:0]  slot;

  int errors;
  int checks;
  int cyc;
  logic [15:0] exp_dout;
  bit          both_seen;

  int          valid_cycs[$];
  logic [15:0] valid_vals[$];
  int          err_cycs[$];
  logic [15:0] err_douts[$];

  tdm_demux16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sync       (sync),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_err  (frame_err),
    .slot       (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every output pulse with its edge number and the dout at that time.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (dout_valid) begin
      valid_cycs.push_back(cyc);
      valid_vals.push_back(dout);
    end
    if (frame_err) begin
      err_cycs.push_back(cyc);
      err_douts.push_back(dout);
    end
    if (dout_valid && frame_err) both_seen = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  function automatic logic [16:0] mk(input logic [15:0] v, input logic bad);
    mk = {(^v) ^ bad, v};
  endfunction

  task automatic clear_log();
    valid_cycs.delete();
    valid_vals.delete();
    err_cycs.delete();
    err_douts.delete();
  endtask

  task automatic drive(input logic e, input logic s, input logic d);
    @(negedge clk);
    en   = e;
    sync = s;
    din  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Sends the first n slots of bits (sync on slot 0), with up to gap_max
  // en=0 cycles carrying random sync/din after each slot.
  task automatic send_bits(input logic [16:0] bits, input int n, input int gap_max,
                           output int last_edge);
    last_edge = 0;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, (i == 0), bits[i]);
      last_edge = cyc + 1;
      if (gap_max > 0) begin
        int g;
        g = $urandom_range(gap_max, 0);
        repeat (g) drive(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1; sync = 1'b1; din = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h want 0000", dout); end
    checks++; if (slot !== 5'd0) begin errors++; $display("FAIL reset_slot: got %0d want 0", slot); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
    en = 1'b0; sync = 1'b0; din = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    exp_dout = 16'h0000;
  endtask

  task automatic test_single_frame();
    int le;
    clear_log();
    send_bits(mk(16'hE2A2, 1'b0), N, 0, le);
    idle(2);
    checks++;
    if (valid_cycs.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d pulses want 1", valid_cycs.size());
    end else begin
      checks++; if (valid_cycs[0] != le) begin errors++; $display("FAIL single_latency: pulse edge %0d want %0d", valid_cycs[0], le); end
      checks++; if (valid_vals[0] !== 16'hE2A2) begin errors++; $display("FAIL single_value: got %h want e2a2", valid_vals[0]); end
    end
    checks++; if (dout !== 16'hE2A2) begin errors++; $display("FAIL single_hold: got %h want e2a2", dout); end
    checks++; if (err_cycs.size() != 0) begin errors++; $display("FAIL single_err: got %0d err pulses want 0", err_cycs.size()); end
    checks++; if (slot !== 5'd0) begin errors++; $display("FAIL single_slot_idle: got %0d want 0", slot); end
    exp_dout = 16'hE2A2;
  endtask

  task automatic test_back_to_back();
    int le0, le1;
    clear_log();
    send_bits(mk(16'h4E75, 1'b0), N, 0, le0);
    send_bits(mk(16'h1048, 1'b0), N, 0, le1);
    idle(2);
    checks++;
    if (valid_cycs.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d pulses want 2", valid_cycs.size());
    end else begin
      checks++; if (valid_cycs[1] - valid_cycs[0] != N) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", valid_cycs[1] - valid_cycs[0], N); end
      checks++; if (valid_vals[0] !== 16'h4E75) begin errors++; $display("FAIL b2b_first: got %h want 4e75", valid_vals[0]); end
      checks++; if (valid_vals[1] !== 16'h1048) begin errors++; $display("FAIL b2b_second: got %h want 1048", valid_vals[1]); end
      checks++; if (valid_cycs[1] != le1) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", valid_cycs[1], le1); end
    end
    checks++; if (err_cycs.size() != 0) begin errors++; $display("FAIL b2b_err: got %0d want 0", err_cycs.size()); end
    exp_dout = 16'h1048;
  endtask

  task automatic test_en_gaps();
    logic [16:0] bits;
    int e0;
    bits = mk(16'hFFFF, 1'b0);
    clear_log();
    e0 = 0;
    for (int i = 0; i < N; i++) begin
      drive(1'b1, (i == 0), bits[i]);
      if (i == 0) e0 = cyc + 1;
      if (i > 0) begin
        checks++;
        if (slot !== 5'(i)) begin errors++; $display("FAIL gap_slot_hold: slot %0d want %0d", slot, i); end
      end
      drive(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      checks++;
      if (slot !== 5'((i + 1) % N)) begin errors++; $display("FAIL gap_slot_step: slot %0d want %0d", slot, (i + 1) % N); end
    end
    idle(2);
    checks++;
    if (valid_cycs.size() != 1) begin
      errors++; $display("FAIL gap_count: got %0d pulses want 1", valid_cycs.size());
    end else begin
      checks++; if (valid_cycs[0] - e0 != 2 * (N - 1)) begin errors++; $display("FAIL gap_timing: got %0d want %0d", valid_cycs[0] - e0, 2 * (N - 1)); end
    end
    checks++; if (dout !== 16'hFFFF) begin errors++; $display("FAIL gap_value: got %h want ffff", dout); end
    exp_dout = 16'hFFFF;
  endtask

  task automatic test_early_sync();
    int le_junk, le;
    clear_log();
    send_bits(mk(16'h5A5A, 1'b0), 7, 0, le_junk);
    send_bits(mk(16'h0249, 1'b0), N, 0, le);
    idle(2);
    checks++;
    if (err_cycs.size() != 1) begin
      errors++; $display("FAIL early_err_count: got %0d want 1", err_cycs.size());
    end else begin
      checks++; if (err_cycs[0] != le_junk + 1) begin errors++; $display("FAIL early_err_edge: got %0d want %0d", err_cycs[0], le_junk + 1); end
      checks++; if (err_douts[0] !== exp_dout) begin errors++; $display("FAIL early_dout_kept: got %h want %h", err_douts[0], exp_dout); end
    end
    checks++;
    if (valid_vals.size() != 1) begin
      errors++; $display("FAIL early_valid_count: got %0d want 1", valid_vals.size());
    end else begin
      checks++; if (valid_vals[0] !== 16'h0249) begin errors++; $display("FAIL early_new_frame: got %h want 0249", valid_vals[0]); end
      checks++; if (valid_cycs[0] != le) begin errors++; $display("FAIL early_latency: got %0d want %0d", valid_cycs[0], le); end
    end
    exp_dout = 16'h0249;
  endtask

  task automatic test_reset_mid_frame();
    int le;
    clear_log();
    send_bits(mk(16'h3C3C, 1'b0), 9, 0, le);
    @(negedge clk);
    en = 1'b0;
    checks++; if (slot !== 5'd9) begin errors++; $display("FAIL rstmid_pre_slot: got %0d want 9", slot); end
    rst_n = 1'b0;
    #1;
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL rstmid_dout: got %h want 0000", dout); end
    checks++; if (slot !== 5'd0) begin errors++; $display("FAIL rstmid_slot: got %0d want 0", slot); end
    checks++; if (dout_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: valid %b err %b want 0 0", dout_valid, frame_err); end
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    exp_dout = 16'h0000;
    // en cycles without sync must not start a frame after release.
    repeat (4) drive(1'b1, 1'b0, 1'($urandom_range(1, 0)));
    idle(1);
    checks++; if (slot !== 5'd0) begin errors++; $display("FAIL rstmid_nosync_slot: got %0d want 0", slot); end
    send_bits(mk(16'h1009, 1'b0), N, 0, le);
    idle(2);
    checks++;
    if (valid_vals.size() != 1) begin
      errors++; $display("FAIL rstmid_valid_count: got %0d want 1", valid_vals.size());
    end else begin
      checks++; if (valid_vals[0] !== 16'h1009) begin errors++; $display("FAIL rstmid_frame: got %h want 1009", valid_vals[0]); end
    end
    checks++; if (err_cycs.size() != 0) begin errors++; $display("FAIL rstmid_err: got %0d want 0", err_cycs.size()); end
    exp_dout = 16'h1009;
  endtask

  task automatic test_random();
    logic [15:0] exp_q[$];
    int exp_errs;
    bit prev_abort;
    int le;
    clear_log();
    exp_errs = 0;
    prev_abort = 1'b0;
    for (int f = 0; f < 24; f++) begin
      logic [15:0] v;
      bit abort, bad;
      v = 16'($urandom);
      abort = (f < 23) && ($urandom_range(3, 0) == 0);
      bad = 1'b0;
`ifdef PARITY_CHECK_EN
      bad = ($urandom_range(3, 0) == 0);
`endif
      if (!prev_abort) begin
        int k;
        k = $urandom_range(2, 0);
        repeat (k) drive(1'b1, 1'b0, 1'($urandom_range(1, 0)));
      end
      if (abort) begin
        send_bits(mk(v, bad), $urandom_range(N - 1, 1), 2, le);
        exp_errs++;
      end else begin
        send_bits(mk(v, bad), N, 2, le);
        if (bad) exp_errs++;
        else exp_q.push_back(v);
      end
      prev_abort = abort;
    end
    idle(3);
    checks++;
    if (err_cycs.size() != exp_errs) begin errors++; $display("FAIL rand_err_count: got %0d want %0d", err_cycs.size(), exp_errs); end
    checks++;
    if (valid_vals.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_valid_count: got %0d want %0d", valid_vals.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (valid_vals[i] !== exp_q[i]) begin errors++; $display("FAIL rand_frame[%0d]: got %h want %h", i, valid_vals[i], exp_q[i]); end
      end
    end
    if (exp_q.size() > 0) exp_dout = exp_q[exp_q.size() - 1];
    checks++; if (dout !== exp_dout) begin errors++; $display("FAIL rand_final_dout: got %h want %h", dout, exp_dout); end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    int le;
    clear_log();
    send_bits({1'b0, 16'hE2A2}, N, 0, le);
    idle(2);
    checks++; if (err_cycs.size() != 1) begin errors++; $display("FAIL parity_bad_err: got %0d want 1", err_cycs.size()); end
    checks++; if (valid_cycs.size() != 0) begin errors++; $display("FAIL parity_bad_valid: got %0d want 0", valid_cycs.size()); end
    checks++; if (dout !== exp_dout) begin errors++; $display("FAIL parity_bad_dout: got %h want %h", dout, exp_dout); end
    clear_log();
    send_bits({1'b1, 16'hE2A2}, N, 0, le);
    idle(2);
    checks++; if (valid_cycs.size() != 1 || err_cycs.size() != 0) begin errors++; $display("FAIL parity_good_pulses: valid %0d err %0d want 1 0", valid_cycs.size(), err_cycs.size()); end
    checks++; if (dout !== 16'hE2A2) begin errors++; $display("FAIL parity_good_dout: got %h want e2a2", dout); end
    exp_dout = 16'hE2A2;
  endtask
`endif

  task automatic test_exclusive_pulses();
    checks++;
    if (both_seen) begin errors++; $display("FAIL exclusive_pulses: got both high want never"); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    both_seen = 1'b0;
    exp_dout = 16'h0000;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_en_gaps();
    test_early_sync();
    test_reset_mid_frame();
    test_random();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_exclusive_pulses();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
